// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
//   - funct3 encodings of the CPU load/store size field
//   - bit index of the store flag inside dmem_sel
//   - FSM state encoding (IDLE, WAIT, RESP)
//   - is_misaligned / is_illegal_sel helpers used to flag error responses
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int DMEM_SEL_STORE = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Halves must sit on an even address, words on a multiple of four.
   function automatic logic is_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (funct3)
         F3_H, F3_HU: mis = addr_lo[0];
         F3_W:        mis = (addr_lo != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Stores only know B/H/W; loads additionally know BU/HU.
   function automatic logic is_illegal_sel(input logic [3:0] sel);
      logic ill;
      if (sel[DMEM_SEL_STORE])
         ill = !(sel[2:0] == F3_B || sel[2:0] == F3_H || sel[2:0] == F3_W);
      else
         ill = (sel[2:0] == 3'b011 || sel[2:0] == 3'b110 || sel[2:0] == 3'b111);
      return ill;
   endfunction

endpackage

// File: rtl/dmem_responder_load_align.sv
// load_align: combinational load extractor.
//   raw_word  in  32  word read from storage
//   addr_lo   in  2   byte offset within the word
//   funct3    in  3   load size / signedness
//   result    out 32  byte/half selected and sign- or zero-extended
// Unknown funct3 values give 0; the responder flags those as errors anyway.
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] raw_word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] shifted;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      shifted  = raw_word >> {addr_lo, 3'b000};
      sel_byte = shifted[7:0];
      // Half select uses addr[1] only; addr[0]=1 is a misalignment error.
      sel_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
      result   = 32'h0;
      case (funct3)
         F3_B:    result = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   result = {24'h0, sel_byte};
         F3_H:    result = {{16{sel_half[15]}}, sel_half};
         F3_HU:   result = {16'h0, sel_half};
         F3_W:    result = raw_word;
         default: result = 32'h0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data memory behind a valid/ready request channel with
// programmable wait states and a one-cycle response pulse.
//   clk, rst      clock, synchronous active-high reset
//   req_valid     in   request present, held stable until accepted
//   req_ready     out  high only in IDLE
//   req_addr      in   byte address (ADDR_W bits, wraps naturally)
//   req_wdata     in   store data
//   req_sel       in   [3]=store, [2:0]=funct3
//   resp_valid    out  one-cycle pulse closing a transaction
//   resp_rdata    out  extended load data, 0 for stores/errors/idle
//   resp_err      out  misaligned or illegal sel, qualified by resp_valid
//   dbg_state     out  current FSM state (ST_IDLE/ST_WAIT/ST_RESP)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; address, data and sel are captured only on that
// edge. Nothing else on the request channel is observed.
module dmem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 2
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_sel,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [1:0]        dbg_state
);

   localparam int DEPTH = 1 << (ADDR_W - 2);

   logic [1:0]        state;
   logic [3:0]        wait_cnt;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic [3:0]        lat_sel;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic [31:0]       mem [DEPTH];

   logic              accept;
   logic              enter_resp;
   logic [ADDR_W-1:0] cur_addr;
   logic [31:0]       cur_wdata;
   logic [3:0]        cur_sel;
   logic              cur_store;
   logic              cur_err;
   logic [ADDR_W-3:0] word_idx;
   logic [31:0]       raw_word;
   logic [31:0]       load_data;
   logic [3:0]        byte_en;
   logic [31:0]       wdata_lanes;
   logic              wr_en;

   assign accept = req_valid && req_ready;

   // With zero wait states the commit happens on the accept edge itself, so
   // the transaction fields come straight from the request port in IDLE.
   assign enter_resp = (state == ST_IDLE && accept && WAIT_CYCLES == 0) ||
                       (state == ST_WAIT && wait_cnt == 4'd1);

   always_comb begin
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      cur_sel   = lat_sel;
      if (state == ST_IDLE) begin
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
         cur_sel   = req_sel;
      end
   end

   assign cur_store = cur_sel[DMEM_SEL_STORE];
   assign cur_err   = is_misaligned(cur_sel[2:0], cur_addr[1:0]) ||
                      is_illegal_sel(cur_sel);
   assign word_idx  = cur_addr[ADDR_W-1:2];
   assign raw_word  = mem[word_idx];

   load_align u_load_align (
      .raw_word (raw_word),
      .addr_lo  (cur_addr[1:0]),
      .funct3   (cur_sel[2:0]),
      .result   (load_data)
   );

   // Store data is replicated across lanes so each enabled lane already
   // holds the right bits; byte_en decides which lanes are written.
   always_comb begin
      byte_en     = 4'b0000;
      wdata_lanes = cur_wdata;
      case (cur_sel[2:0])
         F3_B: begin
            byte_en[cur_addr[1:0]] = 1'b1;
            wdata_lanes            = {4{cur_wdata[7:0]}};
         end
         F3_H: begin
            byte_en     = cur_addr[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{cur_wdata[15:0]}};
         end
         F3_W: begin
            byte_en     = 4'b1111;
            wdata_lanes = cur_wdata;
         end
         default: begin
            byte_en     = 4'b0000;
            wdata_lanes = cur_wdata;
         end
      endcase
   end

   // A reset on the would-be commit edge aborts the transaction.
   assign wr_en = enter_resp && cur_store && !cur_err && !rst;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i])
               mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         wait_cnt  <= 4'd0;
         lat_addr  <= '0;
         lat_wdata <= 32'h0;
         lat_sel   <= 4'h0;
         rdata_q   <= 32'h0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_sel   <= req_sel;
                  wait_cnt  <= 4'(WAIT_CYCLES);
                  state     <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1)
                  state <= ST_RESP;
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         // Response payload is captured on the same edge as the write, from
         // the pre-write contents (loads never write, so no hazard).
         if (enter_resp) begin
            err_q   <= cur_err;
            rdata_q <= (cur_err || cur_store) ? 32'h0 : load_data;
         end
      end
   end

   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   assign resp_rdata = resp_valid ? rdata_q : 32'h0;
   assign resp_err   = resp_valid ? err_q : 1'b0;
   assign dbg_state  = state;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
   import mem_pkg::*;

   localparam logic [3:0] SEL_SB  = 4'b1000;
   localparam logic [3:0] SEL_SH  = 4'b1001;
   localparam logic [3:0] SEL_SW  = 4'b1010;
   localparam logic [3:0] SEL_SBU = 4'b1100;
   localparam logic [3:0] SEL_LB  = 4'b0000;
   localparam logic [3:0] SEL_LH  = 4'b0001;
   localparam logic [3:0] SEL_LW  = 4'b0010;
   localparam logic [3:0] SEL_L3  = 4'b0011;
   localparam logic [3:0] SEL_LBU = 4'b0100;
   localparam logic [3:0] SEL_LHU = 4'b0101;

   int checks = 0;
   int errors = 0;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // DUT with two wait states
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [11:0] req_addr  = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_sel   = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [1:0]  dbg_state;

   dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .dbg_state(dbg_state)
   );

   // DUT with zero wait states
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [11:0] b_addr  = '0;
   logic [31:0] b_wdata = '0;
   logic [3:0]  b_sel   = '0;
   logic        b_resp_valid;
   logic [31:0] b_rdata;
   logic        b_err;
   logic [1:0]  b_state;

   dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(b_valid), .req_ready(b_ready),
      .req_addr(b_addr), .req_wdata(b_wdata), .req_sel(b_sel),
      .resp_valid(b_resp_valid), .resp_rdata(b_rdata), .resp_err(b_err),
      .dbg_state(b_state)
   );

   // Driver: one transaction on u_dut, returns at the negedge of the response
   // cycle. lat counts cycles from the accept edge; -1 means no response.
   task automatic do_txn(input logic [3:0] sel, input logic [11:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic er, output int lat);
      lat = -1;
      rd  = 32'h0;
      er  = 1'b0;
      @(negedge clk);
      req_valid = 1'b1;
      req_sel   = sel;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (resp_valid) begin
            lat = n;
            rd  = resp_rdata;
            er  = resp_err;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 00000000", resp_rdata); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", resp_err); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
   endtask

   task automatic test_word;
      logic [31:0] rd; logic er; int lat;
      do_txn(SEL_SW, 12'h010, 32'hDEADBEEF, rd, er, lat);
      checks++; if (lat != 3) begin errors++; $display("FAIL sw_latency got %0d exp 3", lat); end
      checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_resp got %h/%b exp 00000000/0", rd, er); end
      do_txn(SEL_LW, 12'h010, 32'h0, rd, er, lat);
      checks++; if (lat != 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", er); end
      // Outputs return to zero once the pulse is over.
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL idle_zero got %b/%h exp 0/00000000", resp_valid, resp_rdata); end
   endtask

   task automatic test_byte;
      logic [31:0] rd; logic er; int lat;
      do_txn(SEL_SB, 12'h011, 32'h000000A5, rd, er, lat);
      checks++; if (er !== 1'b0 || lat != 3) begin errors++; $display("FAIL sb_resp got err %b lat %0d exp 0/3", er, lat); end
      do_txn(SEL_LB, 12'h011, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb_rdata got %h exp ffffffa5", rd); end
      do_txn(SEL_LBU, 12'h011, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h000000A5) begin errors++; $display("FAIL lbu_rdata got %h exp 000000a5", rd); end
      do_txn(SEL_LW, 12'h010, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'hDEADA5EF) begin errors++; $display("FAIL lw_after_sb got %h exp deada5ef", rd); end
   endtask

   task automatic test_half;
      logic [31:0] rd; logic er; int lat;
      do_txn(SEL_SW, 12'h020, 32'h11223344, rd, er, lat);
      do_txn(SEL_SH, 12'h022, 32'h00008001, rd, er, lat);
      checks++; if (er !== 1'b0 || lat != 3) begin errors++; $display("FAIL sh_resp got err %b lat %0d exp 0/3", er, lat); end
      do_txn(SEL_LH, 12'h022, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_rdata got %h exp ffff8001", rd); end
      do_txn(SEL_LHU, 12'h022, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_rdata got %h exp 00008001", rd); end
      do_txn(SEL_LW, 12'h020, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h80013344) begin errors++; $display("FAIL lw_after_sh got %h exp 80013344", rd); end
      do_txn(SEL_LHU, 12'h020, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h00003344) begin errors++; $display("FAIL lhu_low got %h exp 00003344", rd); end
   endtask

   task automatic test_errors;
      logic [31:0] rd; logic er; int lat;
      do_txn(SEL_LW, 12'h013, 32'h0, rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 3) begin errors++; $display("FAIL lw_misaligned got %b/%h lat %0d exp 1/00000000/3", er, rd, lat); end
      do_txn(SEL_SH, 12'h021, 32'hFFFFFFFF, rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sh_misaligned got %b/%h exp 1/00000000", er, rd); end
      do_txn(SEL_SBU, 12'h020, 32'hFFFFFFFF, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL store_bad_f3 got %b exp 1", er); end
      do_txn(SEL_L3, 12'h020, 32'h0, rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL load_bad_f3 got %b/%h exp 1/00000000", er, rd); end
      do_txn(SEL_LW, 12'h020, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h80013344 || er !== 1'b0) begin errors++; $display("FAIL lw_after_errors got %h/%b exp 80013344/0", rd, er); end
   endtask

   // Zero-wait instance with req_valid held: a new request is presented
   // after each accept, giving one transaction every two cycles.
   task automatic test_back_to_back;
      logic exp_ready;
      @(negedge clk);
      b_valid = 1'b1; b_sel = SEL_SW; b_addr = 12'h008; b_wdata = 32'hCAFEF00D;
      for (int i = 0; i < 7; i++) begin
         exp_ready = (i % 2 == 0);
         checks++; if (b_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", i, b_ready, exp_ready); end
         checks++; if (b_resp_valid !== !exp_ready) begin errors++; $display("FAIL b2b_resp_valid[%0d] got %b exp %b", i, b_resp_valid, !exp_ready); end
         if (i == 1) begin
            checks++; if (b_rdata !== 32'h0 || b_err !== 1'b0) begin errors++; $display("FAIL b2b_sw got %h/%b exp 00000000/0", b_rdata, b_err); end
            b_sel = SEL_LW; b_addr = 12'h008;
         end
         if (i == 3) begin
            checks++; if (b_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_lw got %h exp cafef00d", b_rdata); end
            b_sel = SEL_LHU; b_addr = 12'h00A;
         end
         if (i == 5) begin
            checks++; if (b_rdata !== 32'h0000CAFE) begin errors++; $display("FAIL b2b_lhu got %h exp 0000cafe", b_rdata); end
            b_valid = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_abort_wait;
      logic [31:0] rd; logic er; int lat; int seen;
      do_txn(SEL_SW, 12'h040, 32'h0BADF00D, rd, er, lat);
      @(negedge clk);
      req_valid = 1'b1; req_sel = SEL_SW; req_addr = 12'h040; req_wdata = 32'h12345678;
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL abort_in_wait got %0d exp %0d", dbg_state, ST_WAIT); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL abort_after_rst got ready %b valid %b exp 1/0", req_ready, resp_valid); end
      rst = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_resp got %0d pulses exp 0", seen); end
      do_txn(SEL_LW, 12'h040, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL abort_no_write got %h exp 0badf00d", rd); end
   endtask

   task automatic test_reset_in_resp;
      logic [31:0] rd; logic er; int lat;
      do_txn(SEL_SW, 12'h050, 32'h55AA55AA, rd, er, lat);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_resp got valid %b state %0d exp 0/0", resp_valid, dbg_state); end
      rst = 1'b0;
      do_txn(SEL_LW, 12'h050, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL rst_resp_commit got %h exp 55aa55aa", rd); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_errors();
      test_back_to_back();
      test_abort_wait();
      test_reset_in_resp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the CPU's load/store port (ALU address [11:0], rs2 write data, 4-bit dmem_sel) through a valid/ready request channel and a one-cycle response pulse.
- Adds programmable wait states, byte/half/word lanes, load sign/zero extension and misalignment detection.
- Replaces the zero-latency data memory so the core and future bus masters can be tested against realistic memory timing.

Parameters:
- ADDR_W, 12, byte-address width; storage is 2^(ADDR_W-2) 32-bit words.
- WAIT_CYCLES, 2, extra cycles between request accept and response (0..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; held stable until accepted.
- req_ready  out  1  responder can accept (high only in IDLE).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; bits used depend on size.
- req_sel  in  4  [3]=store, [2:0]=funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only).
- resp_valid  out  1  one-cycle pulse ending a transaction.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; misaligned or illegal sel.

Behaviour:
- Reset: state IDLE, req_ready=1 in the cycle after reset, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Memory contents are not reset.
- Accept: request is taken on a clk edge with req_valid && req_ready. addr, wdata and sel are latched, and req_ready drops the following cycle.
- FSM IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: on accept, load counter with WAIT_CYCLES. Go to WAIT, or straight to RESP when WAIT_CYCLES=0.
  - WAIT: decrement each cycle; at counter==1 go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency: resp_valid is high WAIT_CYCLES+1 cycles after the accept edge. The earliest next accept is the cycle after RESP, so back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles.
- Memory commit: read and write happen on the edge entering RESP, so a load in the next transaction sees a prior store.
- Stores write byte lanes only:
  - SB: lane addr[1:0] gets wdata[7:0].
  - SH: lanes {addr[1],0}..+1 get wdata[15:0].
  - SW: all lanes.
  - Other lanes are unchanged.
- Loads select a byte or half by addr[1:0] / addr[1]. B and H sign-extend; BU and HU zero-extend; W passes the word.
- Errors:
  - Conditions: H/HU with addr[0]=1; W with addr[1:0]!=0; a store with funct3 not in {000,001,010}; a load with funct3 in {011,110,111}.
  - Effect: resp_err=1, resp_rdata=0, no memory write. The transaction completes with normal latency.
- resp_rdata and resp_err are held at 0 whenever resp_valid=0.
- req_valid dropping while not ready is a master protocol violation and is ignored. Nothing is latched outside the accept edge.
- rst in WAIT: abort; no write occurs and no resp_valid is produced.
- rst in the RESP cycle: the write already committed on entry stays in memory, but resp_valid is forced low on the following cycle.
- Address wrap: the top ADDR_W bits only; no out-of-range case exists.

Decomposition:
- Shared package (mem_pkg):
  - funct3 constants F3_B/H/W/BU/HU.
  - DMEM_SEL_STORE bit index.
  - FSM state encoding (IDLE, WAIT, RESP).
  - function is_misaligned(funct3, addr[1:0]).
- Sub-module load_align (combinational): raw word, addr[1:0] and funct3 in; extended 32-bit result out.
- Storage, FSM and lane-write logic live in dmem_responder itself.

Test Plan:
- SW addr 0x010 data 0xDEADBEEF, then LW 0x010 with WAIT_CYCLES=2 -> each resp_valid 3 cycles after its accept; load rdata=0xDEADBEEF, err=0.
- After above, SB 0x011 data 0x000000A5, then LB 0x011 -> 0xFFFFFFA5; LBU 0x011 -> 0x000000A5; LW 0x010 -> 0xDEADA5EF.
- SH 0x022 data 0x00008001, then LH 0x022 -> 0xFFFF8001, LHU 0x022 -> 0x00008001, LW 0x020 -> 0x8001xxxx with the low half unchanged.
- LW 0x013 and SH 0x021 -> resp_err=1, rdata=0; a follow-up LW 0x020 shows the word unchanged.
- Hold req_valid high for 3 loads with WAIT_CYCLES=0 -> accepts exactly every 2 cycles, resp_valid 1 cycle after each accept, req_ready low between.
- SW 0x040 data 0x12345678 with rst asserted during WAIT -> no resp_valid, req_ready=1 the cycle after rst; LW 0x040 returns the prior content, not 0x12345678.
